// File: rtl/seq_mem.sv
// Growing symbol-sequence memory for the Simon Says game: append, play back over
// valid/ready, and check player entries one symbol at a time.
module seq_mem #(
    parameter  int SYM_W = 2,
    parameter  int DEPTH = 32,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_SEQ,
    input  logic             SEQ_CLR,
    input  logic             SEQ_APPEND,
    input  logic [SYM_W-1:0] SEQ_IN,
    input  logic             SEQ_PLAY_START,
    output logic [SYM_W-1:0] SEQ_OUT,
    output logic             SEQ_OUT_VALID,
    input  logic             SEQ_OUT_READY,
    input  logic             SEQ_CHK_START,
    input  logic             SEQ_CHK_VALID,
    input  logic [SYM_W-1:0] SEQ_CHK_IN,
    output logic             SEQ_MATCH,
    output logic             SEQ_MISMATCH,
    output logic             SEQ_ROUND_DONE,
    output logic [LEN_W-1:0] SEQ_LEN,
    output logic             SEQ_FULL,
    output logic             SEQ_BUSY
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             match_q, match_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic             wr_en;
    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [SYM_W-1:0] rd_sym;
    logic             is_last;
    logic             full;

    // Storage resets to zero so SEQ_OUT reads 0 out of reset; SEQ_CLR leaves it intact.
    always_ff @(posedge clk or posedge rst_SEQ) begin
        if (rst_SEQ) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[PTR_W'(len_q)] <= SEQ_IN;
        end
    end

    assign rd_sym  = mem_q[ptr_q];
    assign is_last = (LEN_W'(ptr_q) == (len_q - LEN_W'(1)));
    assign full    = (len_q == LEN_W'(DEPTH));

    always_ff @(posedge clk or posedge rst_SEQ) begin
        if (rst_SEQ) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ptr_q      <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    // A higher-priority request that is asserted masks the lower ones even if it is itself ignored.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        if (SEQ_CLR) begin
            state_d = ST_IDLE;
            len_d   = '0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (SEQ_APPEND) begin
                        if (!full) begin
                            wr_en = 1'b1;
                            len_d = len_q + LEN_W'(1);
                        end
                    end else if (SEQ_PLAY_START) begin
                        if (len_q != '0) begin
                            state_d = ST_PLAY;
                            ptr_d   = '0;
                        end
                    end else if (SEQ_CHK_START) begin
                        if (len_q != '0) begin
                            state_d = ST_CHECK;
                            ptr_d   = '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (SEQ_OUT_READY) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (SEQ_CHK_VALID) begin
                        if (SEQ_CHK_IN == rd_sym) begin
                            match_d = 1'b1;
                            if (is_last) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                                ptr_d   = '0;
                            end else begin
                                ptr_d = ptr_q + PTR_W'(1);
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            state_d    = ST_IDLE;
                            ptr_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    assign SEQ_OUT        = rd_sym;
    assign SEQ_OUT_VALID  = (state_q == ST_PLAY);
    assign SEQ_MATCH      = match_q;
    assign SEQ_MISMATCH   = mismatch_q;
    assign SEQ_ROUND_DONE = done_q;
    assign SEQ_LEN        = len_q;
    assign SEQ_FULL       = full;
    assign SEQ_BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mem.sv
// Bench for seq_mem (DEPTH=4): a queue/array game model checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_seq_mem;

    localparam int SYM_W = 2;
    localparam int DEPTH = 4;
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             append = 1'b0;
    logic [SYM_W-1:0] sym_in = '0;
    logic             play_start = 1'b0;
    logic [SYM_W-1:0] out_sym;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             chk_start = 1'b0;
    logic             chk_valid = 1'b0;
    logic [SYM_W-1:0] chk_in = '0;
    logic             match, mismatch, round_done;
    logic [LEN_W-1:0] seq_len;
    logic             seq_full, seq_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_mem #(.SYM_W(SYM_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_SEQ        (rst),
        .SEQ_CLR        (clr),
        .SEQ_APPEND     (append),
        .SEQ_IN         (sym_in),
        .SEQ_PLAY_START (play_start),
        .SEQ_OUT        (out_sym),
        .SEQ_OUT_VALID  (out_valid),
        .SEQ_OUT_READY  (out_ready),
        .SEQ_CHK_START  (chk_start),
        .SEQ_CHK_VALID  (chk_valid),
        .SEQ_CHK_IN     (chk_in),
        .SEQ_MATCH      (match),
        .SEQ_MISMATCH   (mismatch),
        .SEQ_ROUND_DONE (round_done),
        .SEQ_LEN        (seq_len),
        .SEQ_FULL       (seq_full),
        .SEQ_BUSY       (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Game model: the stored sequence, which activity is running and how far it has got.
    localparam int M_IDLE = 0, M_PLAY = 1, M_CHECK = 2;
    logic [SYM_W-1:0] m_mem [DEPTH];
    int m_len, m_idx, m_mode;
    bit p_match, p_mis, p_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_len <= 0; m_idx <= 0; m_mode <= M_IDLE;
            p_match <= 0; p_mis <= 0; p_done <= 0;
        end else begin
            p_match <= 0; p_mis <= 0; p_done <= 0;
            if (clr) begin
                m_len <= 0; m_idx <= 0; m_mode <= M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (append) begin
                    if (m_len < DEPTH) begin
                        m_mem[m_len] <= sym_in;
                        m_len <= m_len + 1;
                    end
                end else if (play_start) begin
                    if (m_len > 0) begin m_mode <= M_PLAY; m_idx <= 0; end
                end else if (chk_start) begin
                    if (m_len > 0) begin m_mode <= M_CHECK; m_idx <= 0; end
                end
            end else if (m_mode == M_PLAY) begin
                if (out_ready) begin
                    if (m_idx == m_len - 1) begin m_mode <= M_IDLE; m_idx <= 0; end
                    else m_idx <= m_idx + 1;
                end
            end else if (chk_valid) begin
                if (chk_in == m_mem[m_idx]) begin
                    p_match <= 1;
                    if (m_idx == m_len - 1) begin
                        p_done <= 1; m_mode <= M_IDLE; m_idx <= 0;
                    end else m_idx <= m_idx + 1;
                end else begin
                    p_mis <= 1; m_mode <= M_IDLE; m_idx <= 0;
                end
            end
        end
    end

    // Per-cycle compare against the model; also logs every playback handshake.
    logic [SYM_W-1:0] hs_log [$];
    always @(negedge clk) begin
        if (!rst) begin
            chk("len", int'(seq_len), m_len);
            chk("full", int'(seq_full), int'(m_len == DEPTH));
            chk("busy", int'(seq_busy), int'(m_mode != M_IDLE));
            chk("valid", int'(out_valid), int'(m_mode == M_PLAY));
            chk("out", int'(out_sym), int'(m_mem[m_idx]));
            chk("match", int'(match), int'(p_match));
            chk("mismatch", int'(mismatch), int'(p_mis));
            chk("round_done", int'(round_done), int'(p_done));
            if (out_valid && out_ready) hs_log.push_back(out_sym);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input int n, input int s0, input int s1, input int s2);
        chk({name, "_count"}, hs_log.size(), n);
        if (hs_log.size() == n && n == 3) begin
            chk({name, "_0"}, int'(hs_log[0]), s0);
            chk({name, "_1"}, int'(hs_log[1]), s1);
            chk({name, "_2"}, int'(hs_log[2]), s2);
        end
    endtask

    initial begin
        int syms [5];
        syms = '{0, 1, 2, 3, 1};

        // Reset state
        #1;
        chk("rst_len", int'(seq_len), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_out", int'(out_sym), 0);
        step(); step();
        rst = 1'b0;
        step();
        chk("rel_len", int'(seq_len), 0);
        chk("rel_full", int'(seq_full), 0);
        chk("rel_busy", int'(seq_busy), 0);
        chk("rel_pulses", int'({match, mismatch, round_done}), 0);

        // SEQ_CHK_VALID in IDLE gives no pulse
        chk_valid = 1; chk_in = 0;
        step();
        chk_valid = 0;
        chk("idle_chk_nopulse", int'({match, mismatch}), 0);

        // Append 3,1,2
        append = 1; sym_in = 3; step();
        sym_in = 1; step();
        sym_in = 2; step();
        append = 0;
        chk("len_after_append", int'(seq_len), 3);

        // Playback with READY held high
        hs_log.delete();
        out_ready = 1; play_start = 1;
        step();
        play_start = 0;
        chk("p1_out0", int'(out_sym), 3); chk("p1_v0", int'(out_valid), 1);
        step();
        chk("p1_out1", int'(out_sym), 1); chk("p1_v1", int'(out_valid), 1);
        step();
        chk("p1_out2", int'(out_sym), 2); chk("p1_v2", int'(out_valid), 1);
        step();
        chk("p1_v3", int'(out_valid), 0); chk("p1_busy", int'(seq_busy), 0);
        out_ready = 0;
        step();
        check_log("p1_log", 3, 3, 1, 2);

        // Playback with READY 1,0,0,1,1
        hs_log.delete();
        out_ready = 1; play_start = 1;
        step();
        play_start = 0; out_ready = 1;
        step();
        out_ready = 0;
        step();
        chk("stall_out_a", int'(out_sym), 1); chk("stall_v_a", int'(out_valid), 1);
        out_ready = 0;
        step();
        chk("stall_out_b", int'(out_sym), 1);
        out_ready = 1;
        step();
        chk("p2_out2", int'(out_sym), 2);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("p2_busy", int'(seq_busy), 0);
        step();
        check_log("p2_log", 3, 3, 1, 2);

        // Check round: 3,1,2 all correct
        chk_start = 1; step();
        chk_start = 0; chk_valid = 1; chk_in = 3; step();
        chk("c1_m0", int'(match), 1); chk("c1_d0", int'(round_done), 0);
        chk_in = 1; step();
        chk("c1_m1", int'(match), 1);
        chk_in = 2; step();
        chk("c1_m2", int'(match), 1); chk("c1_d2", int'(round_done), 1);
        chk("c1_busy", int'(seq_busy), 0);
        chk_valid = 0; step();

        // Check round: 3 then wrong 0
        chk_start = 1; step();
        chk_start = 0; chk_valid = 1; chk_in = 3; step();
        chk("c2_m0", int'(match), 1);
        chk_in = 0; step();
        chk("c2_mis", int'(mismatch), 1); chk("c2_match", int'(match), 0);
        chk("c2_busy", int'(seq_busy), 0); chk("c2_len", int'(seq_len), 3);
        chk_valid = 0; step();

        // Clear wins over append in the same cycle
        clr = 1; append = 1; sym_in = 3; step();
        clr = 0; append = 0;
        chk("clr_len", int'(seq_len), 0);

        // Fill a DEPTH=4 memory with five appends
        for (int i = 0; i < 5; i++) begin
            append = 1; sym_in = syms[i]; step();
            if (i == 3) begin
                chk("fill_len4", int'(seq_len), 4); chk("fill_full4", int'(seq_full), 1);
            end
        end
        append = 0;
        chk("fill_len5", int'(seq_len), 4);

        // SEQ_CLR mid-PLAY
        out_ready = 1; play_start = 1; step();
        play_start = 0; step();
        chk("mid_play_out", int'(out_sym), 1);
        clr = 1; step();
        clr = 0; out_ready = 0;
        chk("clr_play_len", int'(seq_len), 0);
        chk("clr_play_valid", int'(out_valid), 0);
        chk("clr_play_busy", int'(seq_busy), 0);

        // Async reset mid-CHECK, away from a clock edge
        append = 1; sym_in = 2; step();
        sym_in = 3; step();
        append = 0; chk_start = 1; step();
        chk_start = 0; chk_valid = 1; chk_in = 2; step();
        chk("pre_rst_match", int'(match), 1);
        #2; rst = 1; #1;
        chk("arst_len", int'(seq_len), 0);
        chk("arst_busy", int'(seq_busy), 0);
        chk("arst_match", int'(match), 0);
        chk("arst_out", int'(out_sym), 0);
        chk_valid = 0;
        step();
        rst = 0;
        step(); step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
